spi_master_xfer: RTL

- SPI master engine that owns the SPI-side port of the shared transfer buffer. It exchanges bytes in place.
- Per byte: fetch the byte at the current buffer address, shift it out on MOSI while sampling MISO, then write the received byte back to the same address.
- The host fills the buffer, pulses start, waits for done, then reads the received data from the same locations.
- SPI mode 0 (CPOL=0, CPHA=0), single chip select.

---
 rtl/spi_master_xfer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/spi_master_xfer.sv
// ============================================================================
// Module   : spi_master_xfer
// Brief    : SPI mode-0 master that exchanges transfer-buffer bytes in place.
//            Define SPI_MASTER_XFER_LSB_FIRST_EN to add the lsb_first port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_master_xfer #(
    parameter int NUM_BYTES = 8192,
    parameter int CLK_DIV   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [$clog2(NUM_BYTES)-1:0] start_addr,
    input  logic [$clog2(NUM_BYTES):0]   xfer_len,
`ifdef SPI_MASTER_XFER_LSB_FIRST_EN
    input  logic                         lsb_first,
`endif
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(NUM_BYTES)-1:0] buf_addr,
    output logic [7:0]                   buf_wr_val,
    input  logic [7:0]                   buf_rd_val,
    output logic                         buf_wr_en,
    output logic                         spi_sclk,
    output logic                         spi_mosi,
    input  logic                         spi_miso,
    output logic                         spi_cs_n
);

    localparam int ADDR_BITS = $clog2(NUM_BYTES);
    localparam int DIV_BITS  = $clog2(CLK_DIV + 1);

    localparam logic [DIV_BITS-1:0]  c_DIV_LAST  = DIV_BITS'(CLK_DIV - 1);
    localparam logic [ADDR_BITS-1:0] c_ADDR_LAST = ADDR_BITS'(NUM_BYTES - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_FETCH = 3'd1;
    localparam logic [2:0] c_LOAD  = 3'd2;
    localparam logic [2:0] c_SETUP = 3'd3;
    localparam logic [2:0] c_SHIFT = 3'd4;
    localparam logic [2:0] c_STORE = 3'd5;
    localparam logic [2:0] c_HOLD  = 3'd6;

    logic [2:0]           r_state;
    logic [2:0]           w_next_state;
    logic [ADDR_BITS-1:0] r_addr;
    logic [ADDR_BITS:0]   r_remaining;
    logic [7:0]           r_tx;
    logic [7:0]           r_rx;
    logic [2:0]           r_bit_cnt;
    logic [DIV_BITS-1:0]  r_div;
    logic                 r_sclk;
    logic                 r_mosi;
    logic                 r_done;
    logic                 w_div_wrap;
    logic                 w_lsb;

    assign w_div_wrap = (r_div == c_DIV_LAST);

`ifdef SPI_MASTER_XFER_LSB_FIRST_EN
    logic r_lsb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lsb <= 1'b0;
        end else if (r_state == c_IDLE && start) begin
            r_lsb <= lsb_first;
        end
    end

    assign w_lsb = r_lsb;
`else
    assign w_lsb = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (start && xfer_len != '0) w_next_state = c_FETCH;
            c_FETCH: w_next_state = c_LOAD;
            c_LOAD:  w_next_state = c_SETUP;
            c_SETUP: if (w_div_wrap) w_next_state = c_SHIFT;
            // The falling edge after the eighth sample closes the byte.
            c_SHIFT: if (w_div_wrap && r_sclk && r_bit_cnt == 3'd7) w_next_state = c_STORE;
            c_STORE: w_next_state = (r_remaining != 1) ? c_FETCH : c_HOLD;
            c_HOLD:  if (w_div_wrap) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state != c_IDLE);
        spi_cs_n   = (r_state == c_IDLE);
        buf_wr_en  = (r_state == c_STORE);
        buf_addr   = r_addr;
        buf_wr_val = r_rx;
        spi_sclk   = r_sclk;
        spi_mosi   = r_mosi;
        done       = r_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_bit_cnt   <= '0;
            r_div       <= '0;
            r_sclk      <= 1'b0;
            r_mosi      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        if (xfer_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_addr      <= start_addr;
                            r_remaining <= xfer_len;
                        end
                    end
                end
                c_LOAD: begin
                    r_tx      <= buf_rd_val;
                    r_mosi    <= w_lsb ? buf_rd_val[0] : buf_rd_val[7];
                    r_bit_cnt <= '0;
                    r_div     <= '0;
                end
                c_SETUP: begin
                    r_div <= w_div_wrap ? '0 : r_div + 1'b1;
                end
                c_SHIFT: begin
                    r_div <= w_div_wrap ? '0 : r_div + 1'b1;
                    if (w_div_wrap) begin
                        r_sclk <= ~r_sclk;
                        if (!r_sclk) begin
                            r_rx <= w_lsb ? {spi_miso, r_rx[7:1]} : {r_rx[6:0], spi_miso};
                        end else if (r_bit_cnt != 3'd7) begin
                            r_tx      <= w_lsb ? {1'b0, r_tx[7:1]} : {r_tx[6:0], 1'b0};
                            r_mosi    <= w_lsb ? r_tx[1] : r_tx[6];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                c_STORE: begin
                    r_remaining <= r_remaining - 1'b1;
                    r_div       <= '0;
                    if (r_remaining != 1) begin
                        r_addr <= (r_addr == c_ADDR_LAST) ? '0 : r_addr + 1'b1;
                    end
                end
                c_HOLD: begin
                    r_div <= w_div_wrap ? '0 : r_div + 1'b1;
                    if (w_div_wrap) r_done <= 1'b1;
                end
                default: begin
                    r_div <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
